// File: rtl/mcs4_rom_bus_ctrl.sv
// mcs4_rom_bus_ctrl
//   ROM-side responder on the MCS-4 4-bit multiplexed bus (4001 style).
//   Tracks the CPU's 8-state instruction cycle from SYNC_N, assembles the
//   12-bit fetch address from the A1/A2/A3 nibbles, reads the instruction
//   byte from program memory over a req/ack port and returns OPR/OPA in
//   M1/M2. Bus-timing faults are reported on two sticky flags.
//
// Ports
//   CLK, RES_N        clock, asynchronous active-low reset
//   SYNC_N            CPU sync, low during X3
//   CM_ROM_N          ROM command line, low in A3 selects this ROM space
//   DATA_I            bus nibble from the CPU
//   DATA_O, DATA_OE   nibble driven to the bus and its enable
//   MEM_REQ, MEM_ADDR program-memory read request and address
//   MEM_ACK, MEM_RDATA read acknowledge and byte (OPR [7:4], OPA [3:0])
//   CYC_STATE         0=UNSYNC, 1..8 = A1,A2,A3,M1,M2,X1,X2,X3
//   LATE_ERR          sticky: no data by the last clock of M1
//   SYNC_ERR          sticky: SYNC_N out of place or missing
//   ERR_CLR           synchronous clear of both sticky flags
module mcs4_rom_bus_ctrl #(
  parameter int unsigned STATE_CLKS = 2
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        SYNC_N,
  input  logic        CM_ROM_N,
  input  logic [3:0]  DATA_I,
  output logic [3:0]  DATA_O,
  output logic        DATA_OE,
  output logic        MEM_REQ,
  output logic [11:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic [3:0]  CYC_STATE,
  output logic        LATE_ERR,
  output logic        SYNC_ERR,
  input  logic        ERR_CLR
);

  typedef enum logic [3:0] {
    ST_UNSYNC = 4'd0,
    ST_A1     = 4'd1,
    ST_A2     = 4'd2,
    ST_A3     = 4'd3,
    ST_M1     = 4'd4,
    ST_M2     = 4'd5,
    ST_X1     = 4'd6,
    ST_X2     = 4'd7,
    ST_X3     = 4'd8
  } cyc_state_t;

  localparam logic [3:0] LAST_SUB = 4'(STATE_CLKS - 1);

  cyc_state_t state;
  logic [3:0] sub;
  logic       sync_d;
  logic [7:0] opbuf;
  logic       valid;
  logic       sel;
  logic       x3_seen;

  logic last;
  logic sync_start;
  logic sync_bad;
  logic ack_hit;
  logic late_set;
  logic x3_miss;

  function automatic cyc_state_t next_of(input cyc_state_t s);
    case (s)
      ST_A1:   next_of = ST_A2;
      ST_A2:   next_of = ST_A3;
      ST_A3:   next_of = ST_M1;
      ST_M1:   next_of = ST_M2;
      ST_M2:   next_of = ST_X1;
      ST_X1:   next_of = ST_X2;
      ST_X2:   next_of = ST_X3;
      ST_X3:   next_of = ST_A1;
      default: next_of = ST_UNSYNC;
    endcase
  endfunction

  assign last       = (sub == LAST_SUB);
  assign sync_start = !SYNC_N && sync_d;
  // A falling SYNC_N is only expected in X3, or one clock early at the end of X2.
  assign sync_bad   = !(state == ST_UNSYNC || state == ST_X3 ||
                        (state == ST_X2 && last));
  assign ack_hit    = MEM_REQ && MEM_ACK;
  assign late_set   = !sync_start && sel && state == ST_M1 && last &&
                      !valid && !ack_hit;
  assign x3_miss    = !sync_start && state == ST_X3 && last &&
                      !x3_seen && SYNC_N;

  assign CYC_STATE = state;

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state    <= ST_UNSYNC;
      sub      <= '0;
      sync_d   <= 1'b1;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      opbuf    <= '0;
      valid    <= 1'b0;
      sel      <= 1'b0;
      x3_seen  <= 1'b0;
      LATE_ERR <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      sync_d <= SYNC_N;

      // A late ack (in M2) still retires the request but the cycle stays a NOP.
      if (ack_hit) begin
        opbuf   <= MEM_RDATA;
        MEM_REQ <= 1'b0;
        if (state == ST_M1) valid <= 1'b1;
      end

      if (sync_start) begin
        // The current clock counts as X3 sub 0.
        if (STATE_CLKS == 1) begin
          state   <= ST_A1;
          sub     <= '0;
          x3_seen <= 1'b0;
        end else begin
          state   <= ST_X3;
          sub     <= 4'd1;
          x3_seen <= 1'b1;
        end
        if (sync_bad) begin
          MEM_REQ <= 1'b0;
          valid   <= 1'b0;
          sel     <= 1'b0;
        end
      end else if (state != ST_UNSYNC) begin
        if (state == ST_X3 && !SYNC_N) x3_seen <= 1'b1;
        if (last) begin
          sub   <= '0;
          state <= next_of(state);
          case (state)
            ST_A1: MEM_ADDR[3:0] <= DATA_I;
            ST_A2: MEM_ADDR[7:4] <= DATA_I;
            ST_A3: begin
              MEM_ADDR[11:8] <= DATA_I;
              sel            <= !CM_ROM_N;
              MEM_REQ        <= !CM_ROM_N;
              valid          <= 1'b0;
            end
            ST_M2: begin
              MEM_REQ <= 1'b0;
              valid   <= 1'b0;
              sel     <= 1'b0;
            end
            ST_X3: begin
              x3_seen <= 1'b0;
              if (!x3_seen && SYNC_N) state <= ST_UNSYNC;
            end
            default: ;
          endcase
        end else begin
          sub <= sub + 4'd1;
        end
      end

      if (late_set)                     LATE_ERR <= 1'b1;
      else if (ERR_CLR)                 LATE_ERR <= 1'b0;

      if ((sync_start && sync_bad) || x3_miss) SYNC_ERR <= 1'b1;
      else if (ERR_CLR)                        SYNC_ERR <= 1'b0;
    end
  end

  // Bus drive: M1 may forward OPR straight from a same-cycle ack.
  always_comb begin
    DATA_OE = 1'b0;
    DATA_O  = '0;
    if (sel) begin
      case (state)
        ST_M1: begin
          DATA_OE = 1'b1;
          if (valid)        DATA_O = opbuf[7:4];
          else if (ack_hit) DATA_O = MEM_RDATA[7:4];
        end
        ST_M2: begin
          DATA_OE = 1'b1;
          if (valid) DATA_O = opbuf[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule
